// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, FSM states, widths.
package alu_pkg;

   localparam int XLEN = 32;
   localparam int NREQ = 2;

   typedef enum logic [4:0] {
      OP_ADD  = 5'b00000,
      OP_SUB  = 5'b00001,
      OP_AND  = 5'b00010,
      OP_OR   = 5'b00011,
      OP_XOR  = 5'b00100,
      OP_SLL  = 5'b00101,
      OP_SRL  = 5'b00110,
      OP_SRA  = 5'b00111,
      OP_MUL  = 5'b01000,
      OP_DIV  = 5'b01001,
      OP_REM  = 5'b01010,
      OP_SLT  = 5'b01011,
      OP_SLTU = 5'b01100,
      OP_SEQ  = 5'b01101,
      OP_NOR  = 5'b01110,
      OP_SNE  = 5'b01111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   function automatic logic is_addsub(input logic [4:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
interface alu_arbiter_if;
   import alu_pkg::*;

   logic [NREQ-1:0]            req_i;
   logic [NREQ-1:0][4:0]       opcode_i;
   logic [NREQ-1:0][XLEN-1:0]  op1_i;
   logic [NREQ-1:0][XLEN-1:0]  op2_i;
   logic [NREQ-1:0][4:0]       shamt_i;
   logic [NREQ-1:0]            grant_o;
   logic [NREQ-1:0]            done_o;
   logic [XLEN-1:0]            result_o;
   logic                       zero_o;
   logic                       ovf_o;
   logic                       busy_o;

   modport master (
      output req_i, opcode_i, op1_i, op2_i, shamt_i,
      input  grant_o, done_o, result_o, zero_o, ovf_o, busy_o
   );

   modport slave (
      input  req_i, opcode_i, op1_i, op2_i, shamt_i,
      output grant_o, done_o, result_o, zero_o, ovf_o, busy_o
   );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU; opcodes outside the defined set yield zero.
module alu
   import alu_pkg::*;
(
   input  logic [4:0]      opcode,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [4:0]      shamt,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            ovf
);

   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;

   assign sum  = op1 + op2;
   assign diff = op1 - op2;

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      case (opcode)
         OP_ADD: begin
            result = sum;
            ovf    = (op1[XLEN-1] == op2[XLEN-1]) && (sum[XLEN-1] != op1[XLEN-1]);
         end
         OP_SUB: begin
            result = diff;
            ovf    = (op1[XLEN-1] != op2[XLEN-1]) && (diff[XLEN-1] != op1[XLEN-1]);
         end
         OP_AND:  result = op1 & op2;
         OP_OR:   result = op1 | op2;
         OP_XOR:  result = op1 ^ op2;
         OP_SLL:  result = op1 << shamt;
         OP_SRL:  result = op1 >> shamt;
         OP_SRA:  result = XLEN'($signed(op1) >>> shamt);
         OP_MUL:  result = op1 * op2;
         // Divide/remainder by zero pass the dividend through unchanged.
         OP_DIV:  result = (op2 == '0) ? op1 : op1 / op2;
         OP_REM:  result = (op2 == '0) ? op1 : op1 % op2;
         OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
         OP_SLTU: result = {{(XLEN-1){1'b0}}, (op1 < op2)};
         OP_SEQ:  result = {{(XLEN-1){1'b0}}, (op1 == op2)};
         OP_NOR:  result = ~(op1 | op2);
         OP_SNE:  result = {{(XLEN-1){1'b0}}, (op1 != op2)};
         default: result = '0;
      endcase
      if (!is_addsub(opcode)) begin
         ovf = 1'b0;
      end
      zero = (result == '0);
   end

endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_pick
         assign grant[gi] = req[gi] & (~req[1-gi] | (last != 1'(gi)));
      end
   endgenerate

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters (IDLE->EXEC->RESP).
// Optional build macro ALU_ARB_OVF_TRAP_EN: overflowing add/sub captures zero and keeps zero_o.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int EXEC_CYCLES = 1
) (
   input  logic          clock,
   input  logic          reset,
   alu_arbiter_if.slave  bus
);

   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

   arb_state_e      state_reg;
   logic [3:0]      count_reg;
   logic [1:0]      grant_reg;
   logic [1:0]      done_reg;
   logic            last_reg;
   logic            busy_reg;
   logic [4:0]      opcode_reg;
   logic [4:0]      shamt_reg;
   logic [XLEN-1:0] op1_reg;
   logic [XLEN-1:0] op2_reg;
   logic [XLEN-1:0] result_reg;
   logic            zero_reg;
   logic            ovf_reg;

   logic [1:0]      pick;
   logic            pick_idx;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;
   logic            alu_ovf;

   rr_pick2 u_pick (
      .req   (bus.req_i),
      .last  (last_reg),
      .grant (pick)
   );

   assign pick_idx = pick[1];

   // The ALU only ever sees the latched operands, so requester inputs may move freely.
   alu u_alu (
      .opcode (opcode_reg),
      .op1    (op1_reg),
      .op2    (op2_reg),
      .shamt  (shamt_reg),
      .result (alu_result),
      .zero   (alu_zero),
      .ovf    (alu_ovf)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         count_reg  <= '0;
         grant_reg  <= '0;
         done_reg   <= '0;
         last_reg   <= 1'b1;
         busy_reg   <= 1'b0;
         opcode_reg <= '0;
         shamt_reg  <= '0;
         op1_reg    <= '0;
         op2_reg    <= '0;
         result_reg <= '0;
         zero_reg   <= 1'b1;
         ovf_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (|bus.req_i) begin
                  opcode_reg <= bus.opcode_i[pick_idx];
                  op1_reg    <= bus.op1_i[pick_idx];
                  op2_reg    <= bus.op2_i[pick_idx];
                  shamt_reg  <= bus.shamt_i[pick_idx];
                  grant_reg  <= pick;
                  count_reg  <= CNT_LOAD;
                  busy_reg   <= 1'b1;
                  state_reg  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (count_reg == '0) begin
`ifdef ALU_ARB_OVF_TRAP_EN
                  if (alu_ovf) begin
                     result_reg <= '0;
                     ovf_reg    <= 1'b1;
                  end else begin
                     result_reg <= alu_result;
                     zero_reg   <= alu_zero;
                     ovf_reg    <= 1'b0;
                  end
`else
                  result_reg <= alu_result;
                  zero_reg   <= alu_zero;
                  ovf_reg    <= alu_ovf;
`endif
                  done_reg  <= grant_reg;
                  state_reg <= ST_RESP;
               end else begin
                  count_reg <= count_reg - 4'd1;
               end
            end
            ST_RESP: begin
               done_reg  <= '0;
               grant_reg <= '0;
               last_reg  <= grant_reg[1];
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.grant_o  = grant_reg;
   assign bus.done_o   = done_reg;
   assign bus.result_o = result_reg;
   assign bus.zero_o   = zero_reg;
   assign bus.ovf_o    = ovf_reg;
   assign bus.busy_o   = busy_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (EXEC_CYCLES=1 and EXEC_CYCLES=4 instances).
module tb_alu_arbiter;
   import alu_pkg::*;

`ifdef ALU_ARB_OVF_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   chk_cnt  = 0;
   int   pass_cnt = 0;

   alu_arbiter_if ifa ();
   alu_arbiter_if ifb ();

   alu_arbiter #(.EXEC_CYCLES(1)) dut_a (.clock(clk), .reset(rst), .bus(ifa.slave));
   alu_arbiter #(.EXEC_CYCLES(4)) dut_b (.clock(clk), .reset(rst), .bus(ifb.slave));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      ifa.req_i = '0; ifa.opcode_i = '0; ifa.op1_i = '0; ifa.op2_i = '0; ifa.shamt_i = '0;
      ifb.req_i = '0; ifb.opcode_i = '0; ifb.op1_i = '0; ifb.op2_i = '0; ifb.shamt_i = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      tick();
      tick();
      chk_cnt++; if (ifa.grant_o !== 2'b00) $display("FAIL rst_grant: got %b want 00", ifa.grant_o); else pass_cnt++;
      chk_cnt++; if (ifa.done_o !== 2'b00) $display("FAIL rst_done: got %b want 00", ifa.done_o); else pass_cnt++;
      chk_cnt++; if (ifa.result_o !== 32'h0) $display("FAIL rst_result: got %h want 0", ifa.result_o); else pass_cnt++;
      chk_cnt++; if (ifa.zero_o !== 1'b1) $display("FAIL rst_zero: got %b want 1", ifa.zero_o); else pass_cnt++;
      chk_cnt++; if (ifa.ovf_o !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ifa.ovf_o); else pass_cnt++;
      chk_cnt++; if (ifa.busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", ifa.busy_o); else pass_cnt++;
      chk_cnt++; if (ifb.busy_o !== 1'b0) $display("FAIL rst_busy_b: got %b want 0", ifb.busy_o); else pass_cnt++;
      rst = 1'b0;
      $display("reset: released");
   endtask

   task automatic test_add();
      ifa.req_i = 2'b01; ifa.opcode_i[0] = OP_ADD; ifa.op1_i[0] = 32'd5; ifa.op2_i[0] = 32'd7;
      tick();
      chk_cnt++; if (ifa.grant_o !== 2'b01) $display("FAIL add_grant: got %b want 01", ifa.grant_o); else pass_cnt++;
      chk_cnt++; if (ifa.busy_o !== 1'b1) $display("FAIL add_busy: got %b want 1", ifa.busy_o); else pass_cnt++;
      chk_cnt++; if (ifa.done_o !== 2'b00) $display("FAIL add_early_done: got %b want 00", ifa.done_o); else pass_cnt++;
      ifa.req_i = 2'b00;
      tick();
      chk_cnt++; if (ifa.done_o !== 2'b01) $display("FAIL add_done: got %b want 01", ifa.done_o); else pass_cnt++;
      chk_cnt++; if (ifa.result_o !== 32'd12) $display("FAIL add_result: got %h want c", ifa.result_o); else pass_cnt++;
      chk_cnt++; if (ifa.zero_o !== 1'b0) $display("FAIL add_zero: got %b want 0", ifa.zero_o); else pass_cnt++;
      chk_cnt++; if (ifa.ovf_o !== 1'b0) $display("FAIL add_ovf: got %b want 0", ifa.ovf_o); else pass_cnt++;
      $display("txn req0 ADD 5+7 -> %h", ifa.result_o);
      tick();
      chk_cnt++; if (ifa.done_o !== 2'b00) $display("FAIL add_done_width: got %b want 00", ifa.done_o); else pass_cnt++;
      chk_cnt++; if (ifa.grant_o !== 2'b00) $display("FAIL add_grant_clr: got %b want 00", ifa.grant_o); else pass_cnt++;
      chk_cnt++; if (ifa.busy_o !== 1'b0) $display("FAIL add_busy_clr: got %b want 0", ifa.busy_o); else pass_cnt++;
      chk_cnt++; if (ifa.result_o !== 32'd12) $display("FAIL add_hold: got %h want c", ifa.result_o); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ifa.req_i = 2'b11;
      ifa.opcode_i[0] = OP_SUB; ifa.op1_i[0] = 32'd3;    ifa.op2_i[0] = 32'd3;
      ifa.opcode_i[1] = OP_OR;  ifa.op1_i[1] = 32'hF0;   ifa.op2_i[1] = 32'h0F;
      tick();
      chk_cnt++; if (ifa.grant_o !== 2'b01) $display("FAIL rr_first_grant: got %b want 01", ifa.grant_o); else pass_cnt++;
      tick();
      chk_cnt++; if (ifa.done_o !== 2'b01) $display("FAIL rr_first_done: got %b want 01", ifa.done_o); else pass_cnt++;
      chk_cnt++; if (ifa.result_o !== 32'h0) $display("FAIL rr_sub_result: got %h want 0", ifa.result_o); else pass_cnt++;
      chk_cnt++; if (ifa.zero_o !== 1'b1) $display("FAIL rr_sub_zero: got %b want 1", ifa.zero_o); else pass_cnt++;
      $display("txn req0 SUB 3-3 -> %h", ifa.result_o);
      tick();
      chk_cnt++; if (ifa.grant_o !== 2'b00) $display("FAIL rr_idle_grant: got %b want 00", ifa.grant_o); else pass_cnt++;
      tick();
      chk_cnt++; if (ifa.grant_o !== 2'b10) $display("FAIL rr_second_grant: got %b want 10", ifa.grant_o); else pass_cnt++;
      tick();
      chk_cnt++; if (ifa.done_o !== 2'b10) $display("FAIL rr_second_done: got %b want 10", ifa.done_o); else pass_cnt++;
      chk_cnt++; if (ifa.result_o !== 32'hFF) $display("FAIL rr_or_result: got %h want ff", ifa.result_o); else pass_cnt++;
      chk_cnt++; if (ifa.zero_o !== 1'b0) $display("FAIL rr_or_zero: got %b want 0", ifa.zero_o); else pass_cnt++;
      $display("txn req1 OR f0|0f -> %h", ifa.result_o);
      tick();
      tick();
      chk_cnt++; if (ifa.grant_o !== 2'b01) $display("FAIL rr_third_grant: got %b want 01", ifa.grant_o); else pass_cnt++;
      ifa.req_i = 2'b00;
      tick();
      chk_cnt++; if (ifa.done_o !== 2'b01) $display("FAIL rr_third_done: got %b want 01", ifa.done_o); else pass_cnt++;
      $display("txn req0 SUB 3-3 -> %h", ifa.result_o);
      tick();
   endtask

   task automatic test_overflow();
      logic [31:0] exp_res;
      ifa.req_i = 2'b01; ifa.opcode_i[0] = OP_ADD; ifa.op1_i[0] = 32'h7FFF_FFFF; ifa.op2_i[0] = 32'h1;
      tick();
      ifa.req_i = 2'b00;
      tick();
      exp_res = TRAP ? 32'h0 : 32'h8000_0000;
      chk_cnt++; if (ifa.done_o !== 2'b01) $display("FAIL ovf_add_done: got %b want 01", ifa.done_o); else pass_cnt++;
      chk_cnt++; if (ifa.ovf_o !== 1'b1) $display("FAIL ovf_add_flag: got %b want 1", ifa.ovf_o); else pass_cnt++;
      chk_cnt++; if (ifa.result_o !== exp_res) $display("FAIL ovf_add_result: got %h want %h", ifa.result_o, exp_res); else pass_cnt++;
      // Previous capture left zero_o=1; trap mode must keep it, normal mode clears it.
      chk_cnt++; if (ifa.zero_o !== TRAP) $display("FAIL ovf_add_zero: got %b want %b", ifa.zero_o, TRAP); else pass_cnt++;
      $display("txn req0 ADD 7fffffff+1 -> %h ovf %b", ifa.result_o, ifa.ovf_o);
      tick();
      ifa.req_i = 2'b01; ifa.opcode_i[0] = OP_SUB; ifa.op1_i[0] = 32'h8000_0000; ifa.op2_i[0] = 32'h1;
      tick();
      ifa.req_i = 2'b00;
      tick();
      exp_res = TRAP ? 32'h0 : 32'h7FFF_FFFF;
      chk_cnt++; if (ifa.ovf_o !== 1'b1) $display("FAIL ovf_sub_flag: got %b want 1", ifa.ovf_o); else pass_cnt++;
      chk_cnt++; if (ifa.result_o !== exp_res) $display("FAIL ovf_sub_result: got %h want %h", ifa.result_o, exp_res); else pass_cnt++;
      $display("txn req0 SUB 80000000-1 -> %h ovf %b", ifa.result_o, ifa.ovf_o);
      tick();
   endtask

   task automatic test_ops();
      logic [4:0]  op_t  [7];
      logic [31:0] a_t   [7];
      logic [31:0] b_t   [7];
      logic [4:0]  sh_t  [7];
      logic [31:0] res_t [7];
      op_t  = '{5'b00000, 5'b00101, 5'b00111, 5'b01011, 5'b01000, 5'b10101, 5'b00010};
      a_t   = '{32'd1, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd6, 32'd5, 32'h0000_F0F0};
      b_t   = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd7, 32'd5, 32'h0000_0FF0};
      sh_t  = '{5'd0, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
      res_t = '{32'd2, 32'd16, 32'hF800_0000, 32'd1, 32'd42, 32'd0, 32'h0000_00F0};
      for (int i = 0; i < 7; i++) begin
         ifa.req_i = 2'b01; ifa.opcode_i[0] = op_t[i]; ifa.op1_i[0] = a_t[i];
         ifa.op2_i[0] = b_t[i]; ifa.shamt_i[0] = sh_t[i];
         tick();
         ifa.req_i = 2'b00;
         tick();
         chk_cnt++; if (ifa.done_o !== 2'b01) $display("FAIL op%0d_done: got %b want 01", i, ifa.done_o); else pass_cnt++;
         chk_cnt++; if (ifa.result_o !== res_t[i]) $display("FAIL op%0d_result: got %h want %h", i, ifa.result_o, res_t[i]); else pass_cnt++;
         chk_cnt++; if (ifa.zero_o !== (res_t[i] == 32'h0)) $display("FAIL op%0d_zero: got %b want %b", i, ifa.zero_o, (res_t[i] == 32'h0)); else pass_cnt++;
         chk_cnt++; if (ifa.ovf_o !== 1'b0) $display("FAIL op%0d_ovf: got %b want 0", i, ifa.ovf_o); else pass_cnt++;
         $display("txn req0 op %b a %h b %h sh %0d -> %h", op_t[i], a_t[i], b_t[i], sh_t[i], ifa.result_o);
         tick();
      end
   endtask

   task automatic test_exec_cycles();
      ifb.req_i = 2'b10; ifb.opcode_i[1] = OP_DIV; ifb.op1_i[1] = 32'd100; ifb.op2_i[1] = 32'd0;
      tick();
      chk_cnt++; if (ifb.grant_o !== 2'b10) $display("FAIL ex4_grant: got %b want 10", ifb.grant_o); else pass_cnt++;
      ifb.req_i = 2'b00; ifb.op2_i[1] = 32'd4; ifb.op1_i[1] = 32'd8;
      for (int k = 2; k <= 4; k++) begin
         tick();
         chk_cnt++; if (ifb.done_o !== 2'b00) $display("FAIL ex4_early_done_n%0d: got %b want 00", k, ifb.done_o); else pass_cnt++;
      end
      tick();
      chk_cnt++; if (ifb.done_o !== 2'b10) $display("FAIL ex4_done: got %b want 10", ifb.done_o); else pass_cnt++;
      chk_cnt++; if (ifb.result_o !== 32'd100) $display("FAIL ex4_result: got %0d want 100", ifb.result_o); else pass_cnt++;
      $display("txn req1 DIV 100/0 -> %0d", ifb.result_o);
      tick();
   endtask

   task automatic test_reset_mid_exec();
      ifb.req_i = 2'b01; ifb.opcode_i[0] = OP_ADD; ifb.op1_i[0] = 32'd1; ifb.op2_i[0] = 32'd2;
      ifb.opcode_i[1] = OP_ADD; ifb.op1_i[1] = 32'd10; ifb.op2_i[1] = 32'd20;
      tick();
      ifb.req_i = 2'b00;
      repeat (4) tick();
      chk_cnt++; if (ifb.result_o !== 32'd3) $display("FAIL rm_pre_result: got %h want 3", ifb.result_o); else pass_cnt++;
      $display("txn req0 ADD 1+2 -> %h", ifb.result_o);
      tick();
      ifb.req_i = 2'b01;
      tick();
      ifb.req_i = 2'b00;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_cnt++; if (ifb.done_o !== 2'b00) $display("FAIL rm_done: got %b want 00", ifb.done_o); else pass_cnt++;
      chk_cnt++; if (ifb.busy_o !== 1'b0) $display("FAIL rm_busy: got %b want 0", ifb.busy_o); else pass_cnt++;
      chk_cnt++; if (ifb.grant_o !== 2'b00) $display("FAIL rm_grant: got %b want 00", ifb.grant_o); else pass_cnt++;
      ifb.req_i = 2'b11;
      tick();
      chk_cnt++; if (ifb.grant_o !== 2'b01) $display("FAIL rm_tie_grant: got %b want 01", ifb.grant_o); else pass_cnt++;
      ifb.req_i = 2'b00;
      repeat (4) tick();
      chk_cnt++; if (ifb.done_o !== 2'b01) $display("FAIL rm_tie_done: got %b want 01", ifb.done_o); else pass_cnt++;
      chk_cnt++; if (ifb.result_o !== 32'd3) $display("FAIL rm_tie_result: got %h want 3", ifb.result_o); else pass_cnt++;
      $display("txn req0 ADD 1+2 after reset -> %h", ifb.result_o);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_add();
      test_round_robin();
      test_overflow();
      test_ops();
      test_exec_cycles();
      test_reset_mid_exec();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, meaning cycles spent in EXEC per operation (legal 1..15).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req_i[k], k=0..1  input  1  requester k asks for the ALU (level).
REQ-005 SHALL have ports opcode_i[k]  input  5  ALU operation code; op1_i[k], op2_i[k]  input  32  operands; shamt_i[k]  input  5  shift amount.
REQ-006 SHALL have port grant_o  output  2  one-hot, requester currently owning the ALU (0 in IDLE).
REQ-007 SHALL have port done_o  output  2  one-hot, one-cycle pulse marking a valid result for requester k.
REQ-008 SHALL have ports result_o  output  32  registered ALU result; zero_o  output  1  result==0; ovf_o  output  1  signed overflow of the executed add/sub.
REQ-009 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; no other transitions except reset.
REQ-011 In IDLE with any req_i high, SHALL at the edge select a winner, latch its opcode/op1/op2/shamt into internal registers, set grant_o, load counter to EXEC_CYCLES-1, enter EXEC.
REQ-012 Arbitration SHALL be round-robin: with both requesting, the winner is the requester not served last; single requester always wins.
REQ-013 Operands SHALL be sampled only at the grant edge; later changes on a requester's inputs SHALL NOT affect the operation in flight.
REQ-014 In EXEC the counter SHALL decrement each cycle; at the edge where counter==0 the ALU outputs SHALL be captured into result_o/zero_o/ovf_o and state SHALL become RESP.
REQ-015 In RESP done_o SHALL equal grant_o for exactly one cycle; next edge SHALL return to IDLE, clear grant_o, record the served requester as last-served.
REQ-016 Latency SHALL be: req sampled in IDLE at cycle N -> done_o high in cycle N+EXEC_CYCLES+1; throughput one operation per EXEC_CYCLES+2 cycles.
REQ-017 result_o, zero_o, ovf_o SHALL hold their value until the next capture.
REQ-018 ovf_o SHALL be the add overflow flag for opcode 00000, sub overflow flag for 00001, else 0.
REQ-019 Requests arriving while busy_o is high SHALL be ignored until IDLE; a req_i still high in IDLE after done is treated as a new request.
REQ-020 Opcodes 10000-11111 SHALL execute normally and yield result 0, zero_o=1.

Reset
REQ-021 On reset high at an edge, SHALL enter IDLE, clear grant_o, done_o, result_o, ovf_o, counter; zero_o=1; last-served = requester 1 (so requester 0 wins first tie).
REQ-022 Reset mid-EXEC or mid-RESP SHALL discard the operation with no done_o pulse.

Configuration
REQ-023 With macro ALU_ARB_OVF_TRAP_EN defined, an add/sub with overflow SHALL capture result_o=0, assert ovf_o, and skip updating zero_o; without it, the wrapped sum/difference is captured normally with ovf_o set.

Structure
REQ-024 Opcode constants (ADD=00000, SUB=00001, ..., SNE=01111) and the FSM state encoding SHALL live in a shared package alu_pkg.
REQ-025 SHALL instantiate the existing combinational ALU once; round-robin selection SHALL be a sub-module rr_pick2 (inputs req[1:0], last; output one-hot grant).

Verification
REQ-026 Req0 alone, ADD 5+7, EXEC_CYCLES=1 -> done_o=01 at cycle N+2, result_o=12, zero_o=0, ovf_o=0.
REQ-027 Both requesting from reset, req0 SUB 3-3, req1 OR F0|0F -> first done_o=01 result 0 zero_o=1, then done_o=10 result FF.
REQ-028 ADD 7FFFFFFF+1 -> ovf_o=1; result 80000000 without ALU_ARB_OVF_TRAP_EN, 00000000 with it.
REQ-029 EXEC_CYCLES=4, req1 DIV 100/0, op2_i changed during EXEC -> done_o=10 at N+5, result_o=100 (original operands used).
REQ-030 Reset asserted in second EXEC cycle -> no done_o pulse, busy_o=0, grant_o=00 next cycle; subsequent tie goes to req0.
